instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Supplies instruction words to the instruction decoder: opcode, function field and immediates.
- Consumes the decoder's resolved control-flow signals (jump, jumpLink, jump-register, branchE, branchNE) and the ALU zero flag to compute the next PC.
- Sits between instruction memory and the decode/execute datapath.
- Runs a fetch/issue state machine with a req/ack handshake to memory and a valid/ready handshake to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- PC_WIDTH, 32, width of PC, memory address and link value.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  PC_WIDTH  fetch address (= pc); stable while imem_req is high.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/opcode/funct are valid.
- instr_ready  in  1  decode/execute consumes the instruction this cycle.
- instr  out  32  registered instruction word.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- jump  in  1  J/JAL taken (absolute 26-bit target).
- jump_link  in  1  JAL; informational only, link value comes from pc_plus4.
- jump_reg  in  1  JR; target = rs_data.
- branch_eq  in  1  BEQ.
- branch_ne  in  1  BNE.
- zero  in  1  ALU zero flag for the branch compare.
- rs_data  in  32  register rs value for JR.
- pc  out  PC_WIDTH  address of the current instruction.
- pc_plus4  out  PC_WIDTH  pc + 4, modulo 2^PC_WIDTH; used as the JAL link value.
- fault  out  1  sticky misaligned-target flag.

Behaviour:
- Reset values (asynchronous): pc = RESET_PC, state = IDLE, instr = 0, instr_valid = 0, imem_req = 0, fault = 0.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: lasts exactly one cycle after reset deasserts, then goes to FETCH.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_ack: instr <= imem_rdata and go to ISSUE.
  - Same-cycle ack is allowed, so the minimum fetch latency is 1 cycle.
- ISSUE:
  - instr_valid = 1, imem_req = 0.
  - instr, opcode, funct and pc hold stable until instr_ready.
  - Control inputs (jump, jump_reg, branch_eq, branch_ne, zero, rs_data) are sampled only in the cycle where instr_valid && instr_ready; they are ignored at all other times.
  - On accept: pc <= next_pc and go to FETCH, or go to HALT on a fault.
- Next-PC priority, highest first:
  1. jump_reg: rs_data.
  2. jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. (branch_eq && zero) || (branch_ne && !zero): pc_plus4 + (sign_extend(instr[15:0]) << 2).
  4. Otherwise: pc_plus4.
- Arithmetic: all PC sums are modulo 2^PC_WIDTH; wrap from 32'hFFFF_FFFC to 0 is legal and silent.
- Fault:
  - Triggered when the selected next_pc[1:0] != 0 (only reachable via jump_reg).
  - Effect: fault <= 1, pc holds the faulting instruction's address, state goes to HALT.
- HALT: no requests, instr_valid = 0; exits only through reset.
- imem_ack while imem_req = 0 is ignored.
- Throughput: one instruction per 2 cycles minimum (FETCH then ISSUE, with ack and ready both immediate).
- Reset mid-operation: reset during FETCH with an outstanding request drops the request immediately. A late ack arriving after reset release (during IDLE) is ignored.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, then zero-wait ack and ready; imem_rdata = 32'h2008_0005 (ADDI).
  - Required: imem_addr sequence 0, 4, 8; opcode = 6'h08; instr_valid pulses every 2nd cycle.
- Handshake stalls:
  - Stimulus: ack delayed 3 cycles, instr_ready held low 4 cycles.
  - Required: imem_addr stable during the ack wait; instr/pc stable and instr_valid high during the ready wait; no extra requests.
- Branches at pc = 32'h0000_0010, imm = 16'hFFFC:
  - BEQ, zero = 1: next pc = 32'h0000_0004.
  - BEQ, zero = 0: next pc = 32'h0000_0014.
  - BNE, zero = 0: next pc = 32'h0000_0004.
- Jumps:
  - Stimulus: J at pc = 32'h4000_0000 with instr[25:0] = 26'h0000_100.
  - Required: next pc = 32'h4000_0400.
  - Stimulus: JAL from the same pc.
  - Required: pc_plus4 = 32'h4000_0004 during ISSUE.
  - Stimulus: JR with rs_data = 32'h0000_0080 and jump asserted simultaneously.
  - Required: next pc = 32'h0000_0080 (jump_reg wins).
- Fault and wrap:
  - Stimulus: JR with rs_data = 32'h0000_0082.
  - Required: fault = 1, HALT, no further imem_req.
  - Stimulus: sequential fetch from pc = 32'hFFFF_FFFC.
  - Required: next imem_addr = 0.
- Reset mid-operation:
  - Stimulus: assert reset while imem_req = 1, then deliver ack after reset release.
  - Required: imem_req drops in the reset cycle; pc = RESET_PC; the late ack is ignored; the first new request goes to RESET_PC one cycle after release.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch/issue sequencer between instruction memory and decode.
// Fetches the word at pc using a req/ack handshake, then holds it for decode
// under valid/ready. On accept it resolves the next pc from the decoder's
// control-flow inputs. A misaligned target sets a sticky fault and parks the
// block in HALT until reset.
module instruction_fetch #(
    parameter int                     PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    // instruction memory
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    // decode handshake
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         instr,
    output logic [5:0]          opcode,
    output logic [5:0]          funct,
    // resolved control flow from decode/execute
    input  logic                jump,
    input  logic                jump_link,
    input  logic                jump_reg,
    input  logic                branch_eq,
    input  logic                branch_ne,
    input  logic                zero,
    input  logic [31:0]         rs_data,
    // program counter
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Low 28 bits of the pc are replaced by a J/JAL target; upper bits come
    // from pc_plus4 so the jump stays inside the current 256 MB region.
    localparam logic [PC_WIDTH-1:0] JMASK = PC_WIDTH'(32'h0FFF_FFFF);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] jump_tgt;
    logic [PC_WIDTH-1:0] branch_off;
    logic                branch_taken;
    logic                misaligned;
    logic                instr_load;
    logic                pc_load;
    logic                fault_set;

    // jump_link only tells decode to write pc_plus4; nothing here depends on it
    logic                unused_jump_link;
    assign unused_jump_link = jump_link;

    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign pc_plus4  = pc + PC_WIDTH'(4);

    assign jump_tgt     = (pc_plus4 & ~JMASK) | PC_WIDTH'({instr[25:0], 2'b00});
    assign branch_off   = {{(PC_WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
    assign branch_taken = (branch_eq && zero) || (branch_ne && !zero);

    // Next-pc select; jump_reg outranks jump, which outranks a taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg)
            next_pc = PC_WIDTH'(rs_data);
        else if (jump)
            next_pc = jump_tgt;
        else if (branch_taken)
            next_pc = pc_plus4 + branch_off;
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

    // State register; reset also kills any outstanding request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state and handshake outputs; control inputs matter only on accept.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        instr_load  = 1'b0;
        pc_load     = 1'b0;
        fault_set   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_load = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (misaligned) begin
                        fault_set = 1'b1;
                        state_d   = HALT;
                    end else begin
                        pc_load = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers: pc advances only on accept, and holds on a fault
    // so it still points at the offending instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            instr <= '0;
            fault <= 1'b0;
        end else begin
            if (instr_load)
                instr <= imem_rdata;
            if (pc_load)
                pc <= next_pc;
            if (fault_set)
                fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch.
// Expected fetch addresses and instruction words are queued as stimulus is
// driven and compared when the DUT requests or presents them.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        jump, jump_link, jump_reg, branch_eq, branch_ne, zero;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;

    localparam logic [31:0] ADDI = 32'h2008_0005;
    localparam logic [31:0] JR_W = 32'h0200_0008;
    localparam logic [31:0] BEQ  = 32'h1000_FFFC;
    localparam logic [31:0] BNE  = 32'h1400_FFFC;
    localparam logic [31:0] J_W  = 32'h0800_0100;
    localparam logic [31:0] JAL  = 32'h0C00_0100;

    always #5 clk = ~clk;

    instruction_fetch #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .opcode(opcode), .funct(funct),
        .jump(jump), .jump_link(jump_link), .jump_reg(jump_reg),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .zero(zero),
        .rs_data(rs_data), .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] cur_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic ctl_clear();
        jump = 0; jump_link = 0; jump_reg = 0;
        branch_eq = 0; branch_ne = 0; zero = 0; rs_data = 32'h0;
    endtask

    // Serve one fetch: wait for the request, check its address, ack after dly cycles.
    task automatic fetch(input logic [31:0] word, input int dly, input int max_wait);
        int t = 0;
        while (!imem_req && t < max_wait) begin
            @(negedge clk);
            t++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        if (!imem_req) return;
        check("valid_low_in_fetch", 32'(instr_valid), 32'd0);
        cur_pc = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
        check("imem_addr", imem_addr, cur_pc);
        repeat (dly) begin
            @(negedge clk);
            check("addr_stable", imem_addr, cur_pc);
            check("req_held", 32'(imem_req), 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        exp_instr_q.push_back(word);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    // Accept one instruction after dly cycles, applying the given control inputs.
    task automatic issue(input int dly, input logic jr, input logic j, input logic jl,
                         input logic beq, input logic bne, input logic z,
                         input logic [31:0] rs, input logic [31:0] nxt, input logic flt);
        int t = 0;
        logic [31:0] ei;
        while (!instr_valid && t < 8) begin
            @(negedge clk);
            t++;
        end
        check("valid_seen", 32'(instr_valid), 32'd1);
        ei = (exp_instr_q.size() != 0) ? exp_instr_q.pop_front() : 32'hxxxx_xxxx;
        check("instr", instr, ei);
        check("opcode", 32'(opcode), 32'(ei[31:26]));
        check("funct", 32'(funct), 32'(ei[5:0]));
        check("pc", pc, cur_pc);
        check("pc_plus4", pc_plus4, cur_pc + 32'd4);
        check("req_low_in_issue", 32'(imem_req), 32'd0);
        // junk controls while not accepting must have no effect
        jump_reg = 1; rs_data = 32'h3; jump = 1; branch_ne = 1; zero = 0;
        repeat (dly) begin
            @(negedge clk);
            check("valid_held", 32'(instr_valid), 32'd1);
            check("instr_stable", instr, ei);
            check("pc_stable", pc, cur_pc);
            check("no_extra_req", 32'(imem_req), 32'd0);
        end
        instr_ready = 1'b1;
        jump_reg = jr; jump = j; jump_link = jl;
        branch_eq = beq; branch_ne = bne; zero = z; rs_data = rs;
        if (!flt) exp_addr_q.push_back(nxt);
        @(negedge clk);
        instr_ready = 1'b0;
        ctl_clear();
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        fetch(JR_W, 0, 4);
        issue(0, 1, 0, 0, 0, 0, 0, addr, addr, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("req_drop_in_reset", 32'(imem_req), 32'd0);
        check("pc_reset", pc, 32'h0);
        @(negedge clk);
        check("instr_reset", instr, 32'h0);
        check("valid_reset", 32'(instr_valid), 32'd0);
        check("fault_reset", 32'(fault), 32'd0);
        check("req_reset", 32'(imem_req), 32'd0);
        reset = 1'b0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        exp_addr_q.push_back(32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; imem_ack = 0; imem_rdata = 32'hDEAD_BEEF; instr_ready = 0;
        ctl_clear();
        @(negedge clk);
        do_reset();

        // sequential zero-wait fetch; first request one cycle after release
        fetch(ADDI, 0, 1);  issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);
        fetch(ADDI, 0, 0);  issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0);
        fetch(ADDI, 0, 0);  issue(0, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0);

        // handshake stalls
        fetch(ADDI, 3, 0);  issue(4, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0);

        // branches at 0x10
        fetch(BEQ, 0, 0);   issue(0, 0, 0, 0, 1, 0, 1, 0, 32'h4, 0);
        goto_pc(32'h10);
        fetch(BEQ, 0, 0);   issue(0, 0, 0, 0, 1, 0, 0, 0, 32'h14, 0);
        goto_pc(32'h10);
        fetch(BNE, 0, 0);   issue(0, 0, 0, 0, 0, 1, 0, 0, 32'h4, 0);

        // jumps
        goto_pc(32'h4000_0000);
        fetch(J_W, 0, 0);   issue(0, 0, 1, 0, 0, 0, 0, 0, 32'h4000_0400, 0);
        goto_pc(32'h4000_0000);
        fetch(JAL, 1, 0);   issue(1, 0, 1, 1, 0, 0, 0, 0, 32'h4000_0400, 0);
        fetch(JR_W, 0, 0);  issue(0, 1, 1, 0, 0, 0, 0, 32'h80, 32'h80, 0);

        // wrap at top of address space
        goto_pc(32'hFFFF_FFFC);
        fetch(ADDI, 0, 0);  issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        fetch(ADDI, 0, 0);  issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);

        // misaligned JR target
        fetch(JR_W, 0, 0);  issue(0, 1, 0, 0, 0, 0, 0, 32'h82, 32'h0, 1);
        check("fault_set", 32'(fault), 32'd1);
        check("halt_no_valid", 32'(instr_valid), 32'd0);
        check("halt_no_req", 32'(imem_req), 32'd0);
        check("fault_pc", pc, 32'h4);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("halt_req_stays_low", 32'(imem_req), 32'd0);
            check("halt_valid_low", 32'(instr_valid), 32'd0);
            check("fault_sticky", 32'(fault), 32'd1);
        end
        check("halt_instr_kept", instr, JR_W);

        // reset mid-fetch, then a late ack during IDLE
        do_reset();
        fetch(ADDI, 0, 1);  issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);
        check("midop_req", 32'(imem_req), 32'd1);
        check("midop_addr", imem_addr, exp_addr_q.pop_front());
        reset = 1'b1;
        #1;
        check("midop_req_drop", 32'(imem_req), 32'd0);
        check("midop_pc_reset", pc, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        exp_addr_q.delete();
        exp_instr_q.delete();
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("late_ack_instr", instr, 32'h0);
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        check("restart_req", 32'(imem_req), 32'd1);
        exp_addr_q.push_back(32'h0);
        fetch(ADDI, 0, 0);  issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);
        fetch(ADDI, 0, 0);  issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
